// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like data slave: size encodings, byte-enable
// decode and the response-queue entry.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Wide enough for any practical LATENCY-1 countdown.
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             wr;
        logic [31:0]      rdata;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    // Size code 3 falls into the word case on purpose.
    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_like_data_slave_if.sv
// Core-side SRAM-like data port bundle, plus the stall-injection test hook.
interface sram_like_data_slave_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        stall_inject;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, stall_inject,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, stall_inject,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/sram_like_data_slave_resp_queue.sv
// In-order FIFO of pending responses; every live entry counts down in parallel
// and only the head may retire once its count reaches zero.
module sram_like_data_slave_resp_queue
    import sram_like_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_wr,
    input  logic [31:0] push_rdata,
    input  logic        pop,
    output logic        head_ready,
    output resp_entry_t head,
    output logic        full
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_QW = PTR_W + 1;

    resp_entry_t       ent_q [DEPTH];
    resp_entry_t       ent_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_QW-1:0] count_q, count_d;
    logic [DEPTH-1:0]  live;

    // A slot is live when its distance from the read pointer is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
            logic [PTR_W-1:0] off;
            assign off      = PTR_W'(gi) - rd_ptr_q;
            assign live[gi] = {1'b0, off} < count_q;
        end
    endgenerate

    assign head       = ent_q[rd_ptr_q];
    assign head_ready = (count_q != '0) && (head.cnt == '0);
    assign full       = (count_q == CNT_QW'(DEPTH));

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && ent_q[i].cnt != '0)
                ent_d[i].cnt = ent_q[i].cnt - 1'b1;
        end
        // On a full queue the push lands in the slot being popped.
        if (push)
            ent_d[wr_ptr_q] = '{wr: push_wr, rdata: push_rdata, cnt: CNT_W'(LATENCY - 1)};

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_like_data_slave.sv
// Responder for the core's SRAM-like data port: byte-lane scratchpad memory,
// in-order delayed responses, and a stall hook that holds off acceptance.
module sram_like_data_slave
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_like_data_slave_if.slave bus
);
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       rd_word;
    logic              accept;
    logic              head_ready;
    logic              full;
    resp_entry_t       head;
    logic              data_ok_q, data_ok_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              unused_bits;

    assign idx = bus.data_addr[ADDR_W+1:2];
    assign be  = size_to_be(bus.data_size, bus.data_addr[1:0]);

    // No path from data_req: acceptance depends only on queue state and the hook.
    assign bus.data_addr_ok = !bus.stall_inject && (!full || head_ready);
    assign accept           = bus.data_req && bus.data_addr_ok;

    // One array per byte lane so each write enable maps onto its own RAM column.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [2**ADDR_W];
            always_ff @(posedge clk) begin
                if (accept && bus.data_wr && be[gi])
                    mem[idx] <= bus.data_wdata[gi*8 +: 8];
            end
            assign rd_word[gi*8 +: 8] = mem[idx];
        end
    endgenerate

    sram_like_data_slave_resp_queue #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_wr    (bus.data_wr),
        .push_rdata (rd_word),
        .pop        (head_ready),
        .head_ready (head_ready),
        .head       (head),
        .full       (full)
    );

    always_comb begin
        data_ok_d = head_ready;
        rdata_d   = rdata_q;
        if (head_ready)
            rdata_d = head.wr ? 32'h0 : head.rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.data_data_ok = data_ok_q;
    assign bus.data_rdata   = rdata_q;

    assign unused_bits = ^{bus.data_addr[31:ADDR_W+2], head.cnt};

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Bench for sram_like_data_slave: directed steps plus a random phase, checked
// against a response-time/memory model derived from the port's timing rules.
module tb_sram_like_data_slave;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int LAT    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    sram_like_data_slave_if bus ();

    sram_like_data_slave #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each accepted request gets the cycle its data_ok must
    // appear in, max(accept+LAT+1, previous response+1); memory is a plain word array.
    typedef struct {
        int          resp;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [2**ADDR_W];
    int          n_acc = 0;
    int          n_dut_ok = 0;
    int          last_acc_cyc = 0;
    logic        mon_head_ready;
    logic        mon_ok;
    exp_t        mon_e;
    int          mon_first;
    int          mon_nbytes;
    logic [31:0] mon_w;
    logic [ADDR_W-1:0] mon_idx;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_acc    = 0;
            n_dut_ok = 0;
            check32("rst_data_ok", 32'(bus.data_data_ok), 32'd0);
            check32("rst_rdata", bus.data_rdata, 32'd0);
        end else begin
            if (bus.data_data_ok) n_dut_ok++;
            if (exp_q.size() != 0 && exp_q[0].resp == cyc) begin
                check32("resp_data_ok", 32'(bus.data_data_ok), 32'd1);
                check32("resp_rdata", bus.data_rdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check32("idle_data_ok", 32'(bus.data_data_ok), 32'd0);
            end
            mon_head_ready = (exp_q.size() != 0) && (exp_q[0].resp == cyc + 1);
            mon_ok = !bus.stall_inject && (exp_q.size() < DEPTH || mon_head_ready);
            check32("addr_ok", 32'(bus.data_addr_ok), 32'(mon_ok));
            if (bus.data_req && mon_ok) begin
                n_acc++;
                mon_idx = bus.data_addr[ADDR_W+1:2];
                mon_e.resp = cyc + LAT + 1;
                if (exp_q.size() != 0 && exp_q[$].resp + 1 > mon_e.resp)
                    mon_e.resp = exp_q[$].resp + 1;
                if (bus.data_wr) begin
                    mon_nbytes = (bus.data_size == 2'd0) ? 1 : (bus.data_size == 2'd1) ? 2 : 4;
                    mon_first  = (bus.data_size == 2'd0) ? int'(bus.data_addr[1:0]) :
                                 (bus.data_size == 2'd1) ? 2 * int'(bus.data_addr[1]) : 0;
                    mon_w = ref_mem[mon_idx];
                    for (int b = mon_first; b < mon_first + mon_nbytes; b++)
                        mon_w[8*b +: 8] = bus.data_wdata[8*b +: 8];
                    ref_mem[mon_idx] = mon_w;
                    mon_e.data = 32'h0;
                end else begin
                    mon_e.data = ref_mem[mon_idx];
                end
                exp_q.push_back(mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; returns at posedge+1 after the accept edge.
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit rnd_stall);
        int waited;
        waited = 0;
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_size  = size;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
        if (rnd_stall) bus.stall_inject = ($urandom_range(3) == 0);
        @(negedge clk);
        while (!bus.data_addr_ok) begin
            waited++;
            if (waited > 60) begin
                check32("accept_timeout", 32'(waited), 32'd0);
                break;
            end
            step();
            if (rnd_stall) bus.stall_inject = ($urandom_range(3) == 0);
            @(negedge clk);
        end
        last_acc_cyc = cyc;
        step();
        bus.data_req     = 1'b0;
        bus.stall_inject = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] data, output int at);
        int n;
        n    = 0;
        data = 32'h0;
        at   = -1;
        @(negedge clk);
        while (!bus.data_data_ok && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.data_data_ok) check32("resp_timeout", 32'(n), 32'd0);
        else begin
            data = bus.data_rdata;
            at   = cyc;
        end
    endtask

    logic [31:0] d0, d1, hi;
    int          t0, t1, a0, a1, cnt, acc_before;
    int          acc5 [5];
    int          t5 [5];
    logic [31:0] r5 [5];

    initial begin
        bus.data_req     = 1'b0;
        bus.data_wr      = 1'b0;
        bus.data_size    = 2'd0;
        bus.data_addr    = 32'h0;
        bus.data_wdata   = 32'h0;
        bus.stall_inject = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check32("reset_addr_ok", 32'(bus.data_addr_ok), 32'd1);
        check32("reset_data_ok", 32'(bus.data_data_ok), 32'd0);
        check32("reset_rdata", bus.data_rdata, 32'd0);

        // Prefill words 0..127 with nonzero data so later loads are defined.
        step();
        for (int w = 0; w < 128; w++) issue(1'b1, 2'd2, 32'(w * 4), $urandom | 32'h1, 1'b0);
        repeat (20) step();

        // Single load: data_ok exactly LAT+1 cycles after accept.
        issue(1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
        a0 = last_acc_cyc;
        wait_resp(d0, t0);
        check32("load_latency", 32'(t0 - a0), 32'(LAT + 1));
        check32("load_data", d0, ref_mem[64]);

        // Store then load of the same word, back to back.
        step();
        issue(1'b1, 2'd2, 32'h40, 32'hDEADBEEF, 1'b0);
        a0 = last_acc_cyc;
        issue(1'b0, 2'd2, 32'h40, 32'h0, 1'b0);
        a1 = last_acc_cyc;
        check32("b2b_accept_gap", 32'(a1 - a0), 32'd1);
        wait_resp(d0, t0);
        wait_resp(d1, t1);
        check32("store_resp_rdata", d0, 32'h0);
        check32("load_after_store", d1, 32'hDEADBEEF);
        check32("b2b_resp_gap", 32'(t1 - t0), 32'd1);

        // Byte and half stores merged over a zeroed word.
        step();
        issue(1'b1, 2'd2, 32'h40, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 32'h41, 32'h0000AA00, 1'b0);
        issue(1'b1, 2'd1, 32'h42, 32'h12340000, 1'b0);
        issue(1'b0, 2'd2, 32'h40, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) wait_resp(d0, t0);
        check32("merged_word", d0, 32'h1234AA00);

        // Five loads into a DEPTH=4 queue: the 5th waits for the first pop.
        step();
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 2'd2, 32'((i + 4) * 4), 32'h0, 1'b0);
            acc5[i] = last_acc_cyc;
        end
        check32("full_first4_span", 32'(acc5[3] - acc5[0]), 32'd3);
        check32("full_fifth_gap", 32'(acc5[4] - acc5[3]), 32'd2);
        for (int i = 0; i < 5; i++) wait_resp(r5[i], t5[i]);
        for (int i = 0; i < 5; i++) check32("full_load_data", r5[i], ref_mem[i + 4]);
        check32("full_first_latency", 32'(t5[0] - acc5[0]), 32'(LAT + 1));
        check32("full_last_latency", 32'(t5[4] - acc5[4]), 32'(LAT + 1));
        repeat (10) step();

        // stall_inject high for 3 cycles with a request pending.
        acc_before = n_acc;
        bus.stall_inject = 1'b1;
        bus.data_req     = 1'b1;
        bus.data_wr      = 1'b0;
        bus.data_size    = 2'd2;
        bus.data_addr    = 32'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check32("stall_addr_ok", 32'(bus.data_addr_ok), 32'd0);
            @(posedge clk);
            #1;
        end
        check32("stall_no_accept", 32'(n_acc), 32'(acc_before));
        bus.stall_inject = 1'b0;
        @(negedge clk);
        check32("unstall_addr_ok", 32'(bus.data_addr_ok), 32'd1);
        step();
        bus.data_req = 1'b0;
        check32("unstall_accept", 32'(n_acc), 32'(acc_before + 1));
        wait_resp(d0, t0);
        check32("unstall_data", d0, ref_mem[8]);
        repeat (10) step();

        // Async reset with two loads outstanding.
        issue(1'b0, 2'd2, 32'h24, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 32'h28, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check32("async_rst_data_ok", 32'(bus.data_data_ok), 32'd0);
        check32("async_rst_rdata", bus.data_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.data_data_ok) cnt++;
        end
        check32("dropped_after_rst", 32'(cnt), 32'd0);
        step();
        issue(1'b0, 2'd2, 32'h44, 32'h0, 1'b0);
        a0 = last_acc_cyc;
        wait_resp(d0, t0);
        check32("post_rst_latency", 32'(t0 - a0), 32'(LAT + 1));
        check32("post_rst_data", d0, ref_mem[17]);

        // Random mix with aliased upper address bits and random stalls.
        step();
        for (int n = 0; n < 120; n++) begin
            hi = $urandom;
            issue(1'($urandom_range(1)), 2'($urandom_range(3)),
                  (hi & 32'hFFFF_F000) | 32'($urandom_range(511)), $urandom, 1'b1);
            repeat ($urandom_range(2)) step();
        end
        repeat (40) step();
        check32("resp_count", 32'(n_dut_ok), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_like_data_slave.md
Name: sram_like_data_slave

Overview:
- Responder (slave) end of the core's SRAM-like data port (req / wr / size / addr / wdata → addr_ok / data_ok / rdata).
- Backs the port with an on-chip word-addressed memory.
- Queues up to DEPTH outstanding requests and answers them in order after a programmable latency.
- Used as a scratchpad and as the data-side model that exercises the pipeline's data_stall / load-load / data_req_pre paths; a stall-injection input forces addr_ok low on demand.

Parameters:
- ADDR_W, 10, word-index bits; memory is 2^ADDR_W 32-bit words.
- DEPTH, 4, max outstanding accepted-but-unanswered requests (power of 2, ≥2).
- LATENCY, 2, cycles from the acceptance edge to the data_ok cycle (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_req  in  1  request valid.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 byte, 1 half, 2 word; 3 treated as word.
- data_addr  in  32  byte address.
- data_wdata  in  32  store data, already lane-aligned by the core.
- stall_inject  in  1  test hook: forces addr_ok low while high.
- data_addr_ok  out  1  request accepted this cycle when data_req && data_addr_ok.
- data_data_ok  out  1  one-cycle response pulse, in acceptance order.
- data_rdata  out  32  load word, valid when data_data_ok; 0 for store responses.

Behaviour:
- Reset (async, any time): queue emptied, all counters cleared, data_data_ok=0, data_rdata=0. Memory contents are not reset. Outstanding requests are dropped and never answered.
- Index and byte enables:
  - idx = data_addr[ADDR_W+1:2]; upper address bits ignored (aliasing).
  - No alignment check.
  - be: size 0 → 1<<addr[1:0]; size 1 → addr[1] ? 4'b1100 : 4'b0011; size 2/3 → 4'b1111.
- Acceptance (accept = data_req && data_addr_ok), on that clock edge:
  - Store: memory bytes with be set are written from data_wdata.
  - Load: mem[idx] (combinational read of the pre-edge array) is captured into the queue entry.
  - Push entry {wr, rdata_snapshot, cnt=LATENCY-1}.
  - A load accepted after a store always sees that store (program order holds by construction).
- Counters: every cycle, every valid entry with cnt≠0 decrements.
- Head ready: head valid && head.cnt==0.
- Response:
  - data_data_ok and data_rdata are registered.
  - On the edge where head is ready: pop it; next cycle data_data_ok=1 and data_rdata = head.wr ? 0 : snapshot; otherwise data_data_ok=0 and data_rdata holds its last value.
  - Net effect: data_ok comes exactly LATENCY+1 cycles after the accept cycle when the queue is uncongested.
  - Consecutive entries may answer on consecutive cycles (back-to-back data_ok).
  - The master never backpressures data_ok.
- addr_ok:
  - Combinational from state only, no path from data_req: data_addr_ok = !stall_inject && (count<DEPTH || head_ready).
  - Full queue with a pop this edge admits one push (simultaneous push/pop, count unchanged).
- Count is DEPTH-range; pointers wrap modulo DEPTH.
- Empty queue: no data_ok.
- Same-cycle acceptance and response are independent; a newly pushed entry can never be head-ready in its push cycle.
- stall_inject deasserting mid-request: the core keeps data_req high and is accepted on the first cycle addr_ok rises.

Decomposition:
- Shared package sram_like_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - function size_to_be(size, addr_lo);
  - typedef resp_entry_t {wr, rdata[31:0], cnt}.
- Sub-module resp_queue: DEPTH-entry FIFO of resp_entry_t with per-entry countdown, head_ready, push/pop, count.
- The top holds the memory array, byte-enable write, and output registers.

Test Plan:
- After reset, stall_inject=0: addr_ok=1, data_ok=0, rdata=0.
  - Load 0x100, LATENCY=2: data_ok pulses exactly 3 cycles after accept.
- Store word 0xDEADBEEF @0x40, then load @0x40 back-to-back:
  - responses in order: store (rdata 0), then load (rdata 0xDEADBEEF) on the next cycle.
- Byte store 0xAA at 0x41 and half store 0x1234 at 0x42 over word 0:
  - word load at 0x40 returns 0x1234AA00.
- DEPTH=4: 5 loads issued continuously:
  - addr_ok drops after 4 accepts;
  - the 5th is accepted on the cycle the head pops;
  - 5 data_ok pulses, in order, with correct data.
- stall_inject=1 for 3 cycles with data_req high:
  - addr_ok=0 for those 3 cycles, no accept;
  - accept on the 4th cycle.
- Assert rst with 2 loads outstanding:
  - outputs 0 immediately (async);
  - no data_ok after release;
  - a new load completes normally.
